// File: rtl/imem_loader.sv
// Boot-time instruction-memory programmer: turns a header-prefixed byte stream into
// big-endian 32-bit IMem writes and holds the core off until the image is in place.
module imem_loader #(
  parameter int IMEM_SIZE = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [7:0]  In_Data,
  input  logic        In_Valid,
  output logic        In_Ready,
  output logic        WE,
  output logic [31:0] W_Ins,
  output logic [31:0] LD_PC,
  output logic        Busy,
  output logic        Done,
  output logic        Err
);

  // One extra bit so that index == N is representable when N == IMEM_SIZE.
  localparam int IW = $clog2(IMEM_SIZE) + 1;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE
  } state_t;

  state_t         state;
  logic [15:0]    n;
  logic [1:0]     bcnt;
  logic [23:0]    word;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  idx_inc;
  logic [15:0]    hdr_n;
  logic           accept;

  assign In_Ready = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign accept   = In_Valid && In_Ready;
  assign idx_inc  = idx + IW'(1);
  assign hdr_n    = {n[15:8], In_Data};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      n     <= '0;
      bcnt  <= '0;
      word  <= '0;
      idx   <= '0;
      WE    <= 1'b0;
      W_Ins <= '0;
      LD_PC <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Err   <= 1'b0;
    end else begin
      WE <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            Err   <= 1'b0;
            Done  <= 1'b0;
            Busy  <= 1'b1;
            idx   <= '0;
            state <= HDR0;
          end
        end
        HDR0: begin
          if (accept) begin
            n[15:8] <= In_Data;
            state   <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            n[7:0] <= In_Data;
            // Empty or oversize images finish here without touching IMem.
            if (hdr_n == '0) begin
              state <= DONE;
              Done  <= 1'b1;
              Busy  <= 1'b0;
            end else if (hdr_n > 16'(IMEM_SIZE)) begin
              state <= DONE;
              Done  <= 1'b1;
              Busy  <= 1'b0;
              Err   <= 1'b1;
            end else begin
              bcnt  <= '0;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            word <= {word[15:0], In_Data};
            bcnt <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              state <= WRITE;
              WE    <= 1'b1;
              W_Ins <= {word, In_Data};
              LD_PC <= 32'({idx, 2'b00});
            end
          end
        end
        WRITE: begin
          idx <= idx_inc;
          if (16'(idx_inc) == n) begin
            state <= DONE;
            Done  <= 1'b1;
            Busy  <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
